conv_encoder_80211a: RTL and testbench
======================================

# conv_encoder_80211a

Rate-1/2 convolutional encoder (K=7, generators 133/171 octal) with optional puncturing to rate 3/4 or 2/3, as defined for the 802.11a OFDM PHY. It sits between the scrambler and the interleaver. It accepts one data bit per clock and emits the coded/punctured stream serially, one bit per clock, through an internal bit FIFO that absorbs the rate expansion.

## Interface
- FIFO_DEPTH, 512, coded-bit buffer depth in bits; power of two, at least 4.
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  2  0 = rate 1/2; 1 = rate 3/4; 2 = rate 2/3; 3 = treated as 0.
- data_in  in  1  uncoded input bit.
- inputValid  in  1  data_in is sampled on each rising edge where this is 1.
- data_out  out  1  coded output bit, registered.
- outputValid  out  1  data_out carries a valid coded bit this cycle, registered.

## Operation
- Shift register s[5:0] holds the six previous input bits; s[0] is the most recent.
- Let d = data_in.
- A = d ^ s[1] ^ s[2] ^ s[4] ^ s[5] (g0 = 133 octal).
- B = d ^ s[0] ^ s[1] ^ s[2] ^ s[5] (g1 = 171 octal).
- On an accepted input: shift s = {s[4:0], d}, then push coded bits into the FIFO according to the puncture phase p.
- Mode 0 (and 3): push A then B on every input; p is unused.
- Mode 1, p cycles 0→1→2→0:
  - p=0: push A, then B.
  - p=1: push A only.
  - p=2: push B only.
  - Net pattern A0 B0 A1 B2.
- Mode 2, p cycles 0→1→0:
  - p=0: push A, then B.
  - p=1: push A only.
- p advances only on accepted inputs.
- p and s reset to 0 only on reset. mode must be held static while a stream is in progress; changing it mid-stream gives an unspecified puncture alignment but must not corrupt the FIFO.
- Acceptance: an input is accepted when inputValid=1 and the FIFO has free space for the bits that input needs, after accounting for this cycle's pop.
- Overflow: if an input is not accepted, it is dropped. s, p and the FIFO are unchanged. There is no backpressure output.
- Output side: every cycle the FIFO is non-empty, pop one bit into data_out and set outputValid=1.
- When the FIFO is empty, outputValid=0 and data_out holds its last value.
- The FIFO supports up to 2 pushes plus 1 pop in the same cycle. Bits leave in push order (A before B).

## Timing
- Reset values: data_out=0, outputValid=0, s=0, p=0, FIFO empty. Reset asserted mid-stream discards all buffered bits immediately.
- Latency: a bit accepted at edge k is in the FIFO after edge k. Its first coded bit appears on data_out/outputValid after edge k+1 if the FIFO was empty.
- Continuous input at one bit per clock:
  - Mode 0: FIFO occupancy grows by 1 bit per 1 input.
  - Mode 1: grows by 1 bit per 3 inputs.
  - Mode 2: grows by 1 bit per 2 inputs.
  - Once input stops, the output stream runs without gaps until the FIFO is empty.
- Total output bit count for N accepted inputs:
  - Mode 0: 2N.
  - Mode 1: N + ceil(N/3).
  - Mode 2: N + ceil(N/2).
- Example: N=102 gives 204 / 136 / 153 bits for modes 0 / 1 / 2.

## Test plan
- Reset check: hold reset, then release; with inputValid=0 → outputValid=0, data_out=0, and no output for 20 cycles.
- Mode 0 impulse: after reset, inputs 1,0,0,0,0,0,0 back-to-back → serial output 1,1,0,1,1,1,1,1,0,0,1,0,1,1 (14 bits). The first bit appears one cycle after the first accepted input, and outputValid is contiguous.
- Mode 1 impulse: same 7 inputs → 1,1,0,1,1,1,0,0,1,1 (10 bits).
- Mode 2 impulse: same 7 inputs → 1,1,0,1,1,1,0,0,1,1,1 (11 bits).
- Bulk counts: 102 random bits with inputValid held high → exactly 204 / 136 / 153 valid output bits for modes 0/1/2. The bit sequence must match a reference encoder with the same puncture patterns.
- Reset mid-stream: assert reset while the FIFO is non-empty → outputValid=0 the same cycle. After release, the impulse test reproduces the exact vectors above, proving s and p were cleared.

Source files
------------

// File: rtl/conv_encoder_80211a.sv
//------------------------------------------------------------------------------
// conv_encoder_80211a
// K=7 rate-1/2 convolutional encoder (133/171) with 3/4 and 2/3 puncturing,
// serialised through a coded-bit FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module conv_encoder_80211a #(
    parameter int FIFO_DEPTH = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       data_in,
    input  logic       inputValid,
    output logic       data_out,
    output logic       outputValid
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

    logic [5:0]      r_shift;
    logic [1:0]      r_phase;
    logic [c_AW-1:0] r_wrPtr;
    logic [c_AW-1:0] r_rdPtr;
    logic [c_CW-1:0] r_count;
    logic            r_mem [FIFO_DEPTH];

    logic            w_a;
    logic            w_b;
    logic            w_bit0;
    logic            w_bit1;
    logic [1:0]      w_need;
    logic [1:0]      w_phaseNext;
    logic            w_pop;
    logic [c_CW-1:0] w_free;
    logic            w_accept;
    logic [1:0]      w_nPush;
    logic [c_AW-1:0] w_wrPtrInc;

    always_comb begin
        w_a         = data_in ^ r_shift[1] ^ r_shift[2] ^ r_shift[4] ^ r_shift[5];
        w_b         = data_in ^ r_shift[0] ^ r_shift[1] ^ r_shift[2] ^ r_shift[5];
        w_bit0      = w_a;
        w_bit1      = w_b;
        w_need      = 2'd2;
        w_phaseNext = r_phase;
        case (mode)
            2'd1: begin
                case (r_phase)
                    2'd0: w_phaseNext = 2'd1;
                    2'd1: begin
                        w_need      = 2'd1;
                        w_phaseNext = 2'd2;
                    end
                    2'd2: begin
                        w_bit0      = w_b;
                        w_need      = 2'd1;
                        w_phaseNext = 2'd0;
                    end
                    default: w_phaseNext = 2'd0;
                endcase
            end
            2'd2: begin
                // A stale phase of 2 left by a mode switch behaves like phase 0.
                if (r_phase == 2'd1) begin
                    w_need      = 2'd1;
                    w_phaseNext = 2'd0;
                end else begin
                    w_phaseNext = 2'd1;
                end
            end
            default: w_phaseNext = r_phase;
        endcase
    end

    // Space freed by this cycle's pop is usable by this cycle's push.
    assign w_pop      = (r_count != '0);
    assign w_free     = c_DEPTH - r_count + c_CW'(w_pop);
    assign w_accept   = inputValid && (w_free >= c_CW'(w_need));
    assign w_nPush    = w_accept ? w_need : 2'd0;
    assign w_wrPtrInc = r_wrPtr + c_AW'(1);

    always_ff @(posedge clock) begin
        if (w_nPush != 2'd0) begin
            r_mem[r_wrPtr] <= w_bit0;
        end
        if (w_nPush == 2'd2) begin
            r_mem[w_wrPtrInc] <= w_bit1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_phase     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            data_out    <= 1'b0;
            outputValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= {r_shift[4:0], data_in};
                r_phase <= w_phaseNext;
            end
            r_wrPtr <= r_wrPtr + c_AW'(w_nPush);
            r_count <= r_count + c_CW'(w_nPush) - c_CW'(w_pop);
            outputValid <= w_pop;
            if (w_pop) begin
                data_out <= r_mem[r_rdPtr];
                r_rdPtr  <= r_rdPtr + c_AW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_80211a.sv
//------------------------------------------------------------------------------
// tb_conv_encoder_80211a
// Scoreboard bench for conv_encoder_80211a against a reference encoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_conv_encoder_80211a;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       data_in = 1'b0;
    logic       inputValid = 1'b0;
    logic       data_out;
    logic       outputValid;

    conv_encoder_80211a #(.FIFO_DEPTH(512)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .data_in     (data_in),
        .inputValid  (inputValid),
        .data_out    (data_out),
        .outputValid (outputValid)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   outCount = 0;
    int   firstValidCyc = -1;
    int   firstDriveCyc = 0;
    bit   started = 0;
    bit   gap = 0;
    bit   q[$];
    bit   cap[$];
    bit   stim[$];
    logic [5:0] ms = '0;
    int   mp = 0;

    bit v0[14] = '{1,1,0,1,1,1,1,1,0,0,1,0,1,1};
    bit v1[10] = '{1,1,0,1,1,1,0,0,1,1};
    bit v2[11] = '{1,1,0,1,1,1,0,0,1,1,1};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset) begin
            if (outputValid) begin
                bit e;
                if (!started) begin
                    started = 1;
                    firstValidCyc = cyc;
                end
                outCount++;
                cap.push_back(data_out);
                if (q.size() == 0) begin
                    check("extra_out", int'(outputValid), 0);
                end else begin
                    e = q.pop_front();
                    check("data", int'(data_out), int'(e));
                end
            end else if (started && q.size() != 0) begin
                gap = 1;
            end
        end
    end

    // Reference encoder: keep-masks per puncture phase.
    task automatic modelEnc(input bit d);
        bit a, b, kA, kB;
        a = d ^ ms[1] ^ ms[2] ^ ms[4] ^ ms[5];
        b = d ^ ms[0] ^ ms[1] ^ ms[2] ^ ms[5];
        kA = 1; kB = 1;
        if (mode == 2'd1) begin
            kA = (mp != 2);
            kB = (mp != 1);
        end else if (mode == 2'd2) begin
            kB = (mp == 0);
        end
        if (kA) q.push_back(a);
        if (kB) q.push_back(b);
        ms = {ms[4:0], d};
        if (mode == 2'd1) mp = (mp + 1) % 3;
        else if (mode == 2'd2) mp = (mp + 1) % 2;
    endtask

    task automatic doReset();
        reset = 1'b1;
        inputValid = 1'b0;
        q.delete();
        ms = '0;
        mp = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic driveStim(input int m);
        mode = 2'(m);
        started = 0;
        gap = 0;
        outCount = 0;
        firstValidCyc = -1;
        cap.delete();
        foreach (stim[i]) begin
            @(posedge clock);
            #1;
            if (i == 0) firstDriveCyc = cyc;
            data_in = stim[i];
            inputValid = 1'b1;
            modelEnc(stim[i]);
        end
        @(posedge clock);
        #1;
        inputValid = 1'b0;
    endtask

    task automatic runStream(input int m, input int expCount);
        driveStim(m);
        for (int i = 0; i < 2000 && q.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        check("drain_left", q.size(), 0);
        repeat (4) @(negedge clock);
        #1;
        check("out_count", outCount, expCount);
        check("gap", int'(gap), 0);
        check("latency", firstValidCyc, firstDriveCyc + 2);
    endtask

    task automatic impulse(input int m);
        stim.delete();
        stim.push_back(1);
        repeat (6) stim.push_back(0);
        if (m == 0) begin
            runStream(0, 14);
            for (int i = 0; i < 14; i++) check("imp0_bit", (i < cap.size()) ? int'(cap[i]) : -1, int'(v0[i]));
        end else if (m == 1) begin
            runStream(1, 10);
            for (int i = 0; i < 10; i++) check("imp1_bit", (i < cap.size()) ? int'(cap[i]) : -1, int'(v1[i]));
        end else begin
            runStream(2, 11);
            for (int i = 0; i < 11; i++) check("imp2_bit", (i < cap.size()) ? int'(cap[i]) : -1, int'(v2[i]));
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(outputValid), 0);
        check("rst_data", int'(data_out), 0);
        reset = 1'b0;
        outCount = 0;
        repeat (20) @(negedge clock);
        #1;
        check("idle_count", outCount, 0);
        check("idle_valid", int'(outputValid), 0);

        for (int m = 0; m < 3; m++) begin
            doReset();
            impulse(m);
        end

        n = 102;
        for (int m = 0; m < 3; m++) begin
            doReset();
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
            if (m == 0) runStream(0, 2 * n);
            else if (m == 1) runStream(1, n + (n + 2) / 3);
            else runStream(2, n + (n + 1) / 2);
        end

        // Mid-stream reset leaves the phase at 1 in mode 1 before clearing.
        doReset();
        stim.delete();
        for (int i = 0; i < 31; i++) stim.push_back(1'($urandom_range(0, 1)));
        driveStim(1);
        @(negedge clock);
        #1;
        check("pre_rst_valid", int'(outputValid), 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", int'(outputValid), 0);
        check("async_rst_data", int'(data_out), 0);
        q.delete();
        ms = '0;
        mp = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        impulse(1);
        doReset();
        impulse(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
